// File: rtl/fpaddsub_normalize_shift.sv
// fpaddsub_normalize_shift: post-addition normalizer for the single-precision
// FP adder/subtractor. It counts leading zeros on the raw 25-bit mantissa sum
// and normalizes it with a coarse left shift (16 | 12/8/4) in stage 1 and a
// fine left shift (3/2/1/0) in stage 2. On carry-out it shifts right by one
// instead. The exponent is adjusted to match, and zero, underflow and
// overflow are flagged.
// Optional feature macro: FPADDSUB_NORM_STICKY_EN adds the i_sticky/o_sticky
// ports and folds the carry-path dropped LSB into the sticky bit.
module fpaddsub_normalize_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [24:0] i_sum,
  input  logic [7:0]  i_exp,
`ifdef FPADDSUB_NORM_STICKY_EN
  input  logic        i_sticky,
  output logic        o_sticky,
`endif
  output logic        o_valid,
  input  logic        o_ready,
  output logic [22:0] o_mant,
  output logic [7:0]  o_exp,
  output logic        o_zero,
  output logic        o_uflow,
  output logic        o_ovf
);

  // Leading-zero count of a 24-bit value; 24 means the value is all zeros.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Handshake: a stage may load when it is empty or its content moves on.
  logic adv1_s, adv2_s;
  logic v1_r, v2_r;

  assign adv2_s  = !v2_r || o_ready;
  assign adv1_s  = !v1_r || adv2_s;
  assign i_ready = adv1_s;
  assign o_valid = v2_r;

  // Stage 1 signals.
  logic [4:0]  lzc_s;
  logic [23:0] shift16_s;
  logic [23:0] coarse_s;
  logic [23:0] m1_next_s;
  logic [1:0]  fine_next_s;
  logic [8:0]  exp9_next_s;
  logic        zero_next_s;
  logic        carry_s;

  logic [23:0] m1_r;
  logic [1:0]  fine1_r;
  logic [8:0]  exp9_1_r;
  logic        zero1_r;
  logic        carry1_r;

  assign lzc_s = lzc24(i_sum[23:0]);

  // Stage 1 datapath: pick the carry right shift or LZC coarse left shift.
  always_comb begin
    carry_s     = i_sum[24];
    // Two-level coarse shifter: optional 16, then 0/4/8/12.
    shift16_s   = lzc_s[4] ? {i_sum[7:0], 16'h0000} : i_sum[23:0];
    coarse_s    = shift16_s << {lzc_s[3:2], 2'b00};
    m1_next_s   = 24'h000000;
    fine_next_s = 2'b00;
    exp9_next_s = 9'h000;
    zero_next_s = 1'b0;
    if (carry_s) begin
      m1_next_s   = i_sum[24:1];
      fine_next_s = 2'b00;
      exp9_next_s = {1'b0, i_exp} + 9'd1;
      zero_next_s = 1'b0;
    end else begin
      m1_next_s   = coarse_s;
      fine_next_s = lzc_s[1:0];
      exp9_next_s = {1'b0, i_exp} - {4'b0000, lzc_s};
      zero_next_s = (lzc_s == 5'd24);
    end
  end

`ifdef FPADDSUB_NORM_STICKY_EN
  logic sticky1_r;

  // Stage 1 sticky: incoming sticky plus the LSB lost on the carry shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky1_r <= 1'b0;
    end else if (adv1_s && i_valid) begin
      sticky1_r <= i_sticky | (i_sum[24] & i_sum[0]);
    end
  end

  // Stage 2 sticky: carried alongside the data, untouched by left shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sticky <= 1'b0;
    end else if (adv2_s && v1_r) begin
      o_sticky <= sticky1_r;
    end
  end
`endif

  // Stage 1 registers: capture a beat only on a valid handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r     <= 1'b0;
      m1_r     <= 24'h000000;
      fine1_r  <= 2'b00;
      exp9_1_r <= 9'h000;
      zero1_r  <= 1'b0;
      carry1_r <= 1'b0;
    end else if (adv1_s) begin
      v1_r <= i_valid;
      if (i_valid) begin
        m1_r     <= m1_next_s;
        fine1_r  <= fine_next_s;
        exp9_1_r <= exp9_next_s;
        zero1_r  <= zero_next_s;
        carry1_r <= carry_s;
      end
    end
  end

  // Stage 2 signals.
  logic [23:0] shifted_s;
  logic        uflow_s;
  logic [22:0] mant_next_s;
  logic [7:0]  exp_next_s;
  logic        zero_s, uflow_flag_s, ovf_s;

  // Stage 2 datapath: fine shift, then apply flags in priority order.
  always_comb begin
    shifted_s    = m1_r << fine1_r;
    // exp9 <= 0 as a signed 9-bit quantity: negative wrap or exactly zero.
    uflow_s      = exp9_1_r[8] || (exp9_1_r == 9'h000);
    mant_next_s  = shifted_s[22:0];
    exp_next_s   = exp9_1_r[7:0];
    zero_s       = 1'b0;
    uflow_flag_s = 1'b0;
    ovf_s        = 1'b0;
    if (zero1_r) begin
      mant_next_s = 23'h000000;
      exp_next_s  = 8'h00;
      zero_s      = 1'b1;
    end else if (uflow_s) begin
      mant_next_s  = 23'h000000;
      exp_next_s   = 8'h00;
      uflow_flag_s = 1'b1;
    end else if (carry1_r && (exp9_1_r == 9'd255)) begin
      mant_next_s = 23'h000000;
      exp_next_s  = 8'hFF;
      ovf_s       = 1'b1;
    end else begin
      mant_next_s = shifted_s[22:0];
      exp_next_s  = exp9_1_r[7:0];
    end
  end

  // Stage 2 output registers: hold while stalled, load when stage 1 moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      o_mant  <= 23'h000000;
      o_exp   <= 8'h00;
      o_zero  <= 1'b0;
      o_uflow <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        o_mant  <= mant_next_s;
        o_exp   <= exp_next_s;
        o_zero  <= zero_s;
        o_uflow <= uflow_flag_s;
        o_ovf   <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_fpaddsub_normalize_shift.sv
// Scoreboard bench for fpaddsub_normalize_shift: the driver pushes expected
// results from a reference model; a monitor pops and compares on each
// output handshake and checks that stalled outputs hold.
module tb_fpaddsub_normalize_shift;

  typedef struct packed {
    logic [22:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uflow;
    logic        ovf;
    logic        sticky;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [24:0] i_sum = 25'h0;
  logic [7:0]  i_exp = 8'h0;
  logic        i_sticky = 1'b0;
  logic        o_sticky;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [22:0] o_mant;
  logic [7:0]  o_exp;
  logic        o_zero, o_uflow, o_ovf;

  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  exp_t q[$];

  always #5 clk = ~clk;

  fpaddsub_normalize_shift dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_sum(i_sum), .i_exp(i_exp),
`ifdef FPADDSUB_NORM_STICKY_EN
    .i_sticky(i_sticky), .o_sticky(o_sticky),
`endif
    .o_valid(o_valid), .o_ready(o_ready), .o_mant(o_mant), .o_exp(o_exp),
    .o_zero(o_zero), .o_uflow(o_uflow), .o_ovf(o_ovf)
  );

`ifndef FPADDSUB_NORM_STICKY_EN
  assign o_sticky = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [22:0] m, input logic [7:0] e,
                              input logic z, input logic u, input logic o, input logic s);
    exp_t r;
    r.mant = m; r.exp = e; r.zero = z; r.uflow = u; r.ovf = o; r.sticky = s;
    return r;
  endfunction

  // Reference model: value-level normalization by locating the leading one.
  function automatic exp_t model(input logic [24:0] s, input logic [7:0] e, input logic st);
    exp_t   r;
    int     msb, lz, ee;
    longint v;
    r = '0;
    r.sticky = st | (s[24] & s[0]);
    if (s == 25'h0) begin
      r.zero = 1'b1;
    end else if (s[24]) begin
      ee = int'(e) + 1;
      if (ee == 255) begin
        r.ovf = 1'b1; r.exp = 8'd255;
      end else begin
        r.mant = s[23:1]; r.exp = 8'(ee);
      end
    end else begin
      msb = 0;
      for (int b = 0; b < 24; b++) if (s[b]) msb = b;
      lz = 23 - msb;
      ee = int'(e) - lz;
      if (ee <= 0) begin
        r.uflow = 1'b1;
      end else begin
        v = longint'(s) << lz;
        r.mant = 23'(v & 64'h7FFFFF);
        r.exp  = 8'(ee);
      end
    end
    return r;
  endfunction

  task automatic send(input logic [24:0] s, input logic [7:0] e, input logic st, input exp_t x);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      i_valid = 1'b1; i_sum = s; i_exp = e; i_sticky = st;
      #1;
      if (i_ready) begin
        q.push_back(x);
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = ($urandom_range(0, 3) != 0);
        default: o_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare on handshake, verify stability while stalled.
  initial begin
    logic        stall;
    logic [35:0] held, cur;
    exp_t        x;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = {o_valid, o_mant, o_exp, o_zero, o_uflow, o_ovf, o_sticky};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_hold", 64'(cur), 64'(held));
        if (o_valid && o_ready) begin
          stall = 1'b0;
          if (q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            x = q.pop_front();
            chk("mant", 64'(o_mant), 64'(x.mant));
            chk("exp", 64'(o_exp), 64'(x.exp));
            chk("flags", 64'({o_zero, o_uflow, o_ovf}), 64'({x.zero, x.uflow, x.ovf}));
`ifdef FPADDSUB_NORM_STICKY_EN
            chk("sticky", 64'(o_sticky), 64'(x.sticky));
`endif
          end
        end else if (o_valid) begin
          stall = 1'b1;
          held  = cur;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [24:0] d_sum[8];
    logic [7:0]  d_exp[8];
    exp_t        d_x[8];
    int          accepted, k, n;
    logic [24:0] s;
    logic [7:0]  e;
    logic        st;

    d_sum[0] = 25'h0800000; d_exp[0] = 8'd127; d_x[0] = mk(23'h0, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
    d_sum[1] = 25'h1800000; d_exp[1] = 8'd127; d_x[1] = mk(23'h400000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    d_sum[2] = 25'h1800000; d_exp[2] = 8'd254; d_x[2] = mk(23'h0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
    d_sum[3] = 25'h0000400; d_exp[3] = 8'd127; d_x[3] = mk(23'h0, 8'd114, 1'b0, 1'b0, 1'b0, 1'b0);
    d_sum[4] = 25'h0000001; d_exp[4] = 8'd100; d_x[4] = mk(23'h0, 8'd77, 1'b0, 1'b0, 1'b0, 1'b0);
    d_sum[5] = 25'h0000000; d_exp[5] = 8'd127; d_x[5] = mk(23'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    d_sum[6] = 25'h0000400; d_exp[6] = 8'd13;  d_x[6] = mk(23'h0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    d_sum[7] = 25'h1800001; d_exp[7] = 8'd127; d_x[7] = mk(23'h400000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_outputs", 64'({o_mant, o_exp, o_zero, o_uflow, o_ovf}), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);

    // Directed vectors, downstream always ready.
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) send(d_sum[i], d_exp[i], 1'b0, d_x[i]);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure: four beats with LZC 0..3, downstream stalled 3 cycles.
    rdy_mode = 2;
    accepted = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_valid = 1'b1; i_sum = 25'h0800000 >> accepted; i_exp = 8'd127; i_sticky = 1'b0;
      #1;
      if (i_ready) begin
        q.push_back(model(i_sum, i_exp, 1'b0));
        accepted++;
      end
    end
    chk("bp_accepted", 64'(accepted), 64'd2);
    chk("bp_i_ready_low", 64'(i_ready), 64'd0);
    rdy_mode = 0;
    for (int b = 2; b < 4; b++) send(25'h0800000 >> b, 8'd127, 1'b0, mk(23'h0, 8'(127 - b), 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset mid-stream with both stages occupied.
    rdy_mode = 2;
    send(25'h0800000, 8'd50, 1'b0, mk(23'h0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0));
    send(25'h0400000, 8'd50, 1'b0, mk(23'h0, 8'd49, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    chk("full_o_valid", 64'(o_valid), 64'd1);
    chk("full_i_ready", 64'(i_ready), 64'd0);
    i_valid = 1'b0;
    rst = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("mrst_o_valid", 64'(o_valid), 64'd0);
    chk("mrst_outputs", 64'({o_mant, o_exp, o_zero, o_uflow, o_ovf}), 64'd0);
    chk("mrst_i_ready", 64'(i_ready), 64'd1);
    repeat (4) @(negedge clk);

    // Randomized traffic with random backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 400; t++) begin
      k = int'($urandom_range(0, 15));
      if (k == 0) begin
        s = 25'h0;
      end else if (k < 5) begin
        s = {1'b1, 24'($urandom)};
      end else begin
        n = int'($urandom_range(0, 23));
        s = 25'(32'd1 << n) | 25'($urandom & ((32'd1 << n) - 32'd1));
      end
      if (s[24] && ($urandom_range(0, 3) == 0)) e = 8'd254;
      else if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 30));
      else e = 8'($urandom_range(1, 254));
      st = 1'($urandom_range(0, 1));
      send(s, e, st, model(s, e, st));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    rdy_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpaddsub_normalize_shift.md
# fpaddsub_normalize_shift

Post-addition normalization stage for the single-precision FP adder/subtractor; the left-shift counterpart of the alignment shifter. It takes the raw 25-bit mantissa sum plus the pre-normalization exponent and leading-zero-counts it. It then normalizes it with a two-level coarse (16|12|8|4) / fine (3|2|1|0) shift, or a 1-bit right shift on carry-out, and adjusts the exponent. Two-stage valid/ready pipeline sits between the mantissa adder and the rounding/pack stage.

## Interface
- No parameters; widths fixed to IEEE-754 single precision.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  stage can accept a beat this cycle.
- i_sum  in  25  bit 24 = adder carry-out, bit 23 = hidden-bit position, bits 22:0 fraction.
- i_exp  in  8  biased exponent of the larger operand (1..254).
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts beat.
- o_mant  out  23  normalized fraction (hidden bit removed).
- o_exp  out  8  adjusted biased exponent.
- o_zero  out  1  result is exact zero (i_sum == 0).
- o_uflow  out  1  exponent underflow; result flushed to zero.
- o_ovf  out  1  exponent reached 255 on carry path.

## Operation
- Stage 1 (captured when i_valid && i_ready):
  - Carry path (i_sum[24]=1): mantissa = i_sum[24:1], exp9 = i_exp+1, fine=0; dropped LSB goes to sticky (see Configuration).
  - Else LZC = leading zeros of i_sum[23:0], 0..24. LZC=24 sets zero flag. Else coarse left shift by 4*LZC[4:2]; LZC[1:0] stored as fine amount; exp9 = {0,i_exp} - LZC in 9-bit arithmetic.
- Stage 2: left shift by fine amount; o_mant = shifted[22:0].
- Flag rules, priority order:
  - zero: o_mant=0, o_exp=0, o_zero=1.
  - exp9 <= 0 (i_exp <= LZC): o_mant=0, o_exp=0, o_uflow=1. No denormals.
  - carry with exp9 == 255: o_exp=255, o_mant=0, o_ovf=1.
  - otherwise o_exp = exp9[7:0].
- At most one of o_zero/o_uflow/o_ovf is set per beat.
- Handshake:
  - adv2 = !v2 || o_ready.
  - adv1 = !v1 || adv2.
  - i_ready = adv1, combinational from o_ready.
  - No beat dropped or duplicated; order preserved.
- Outputs are registered from stage 2. o_mant, o_exp and flags hold stable while o_valid && !o_ready.

## Timing
- Latency 2 cycles from accepted input to o_valid when o_ready=1; throughput 1 beat/cycle.
- With o_ready=0 the pipe fills 2 beats, then i_ready=0 in the same cycle.
- Simultaneous accept and drain on a full pipe keeps i_ready=1 and both stages advance.
- Reset: v1=v2=0; o_valid=0, o_mant=0, o_exp=0, all flags 0; i_ready=1 the cycle after rst deasserts. Reset mid-stream discards both in-flight beats.
- i_* are ignored when i_valid=0 or i_ready=0 (no capture).

## Configuration
- FPADDSUB_NORM_STICKY_EN:
  - Defined: adds input i_sticky (1) and output o_sticky (1).
  - o_sticky = i_sticky OR (i_sum[0] on carry path), pipelined alongside the data. Left shifts insert zeros and do not modify sticky.
  - Undefined: neither port exists; the carry-path LSB is truncated.

## Test plan
- Hidden-bit only: i_sum=0x0800000, i_exp=127 -> 2 cycles later o_mant=0, o_exp=127, flags 0.
- Carry: i_sum=0x1800000, i_exp=127 -> o_mant=0x400000, o_exp=128. Overflow variant: i_exp=254 -> o_exp=255, o_mant=0, o_ovf=1. With macro, i_sum=0x1800001 -> o_sticky=1.
- Coarse+fine: i_sum=0x0000400 (LZC=13), i_exp=127 -> o_mant=0, o_exp=114. Also i_sum=0x0000001 (LZC=23), i_exp=100 -> o_exp=77.
- Zero and underflow:
  - i_sum=0 -> o_zero=1, o_exp=0.
  - i_sum=0x0000400, i_exp=13 -> o_uflow=1, o_mant=0, o_exp=0.
- Backpressure: stream 4 beats (LZC 0,1,2,3) with o_ready=0 for 3 cycles. Expect i_ready low after 2 accepted and stalled outputs stable. After o_ready=1, all 4 delivered in order with exps 127,126,125,124.
- Reset mid-stream: assert rst with v1=v2=1 -> next cycle o_valid=0, all outputs 0, i_ready=1; no stale beat emitted.
